// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;
   localparam logic [3:0] OP_SRA = 4'b1010;
   localparam logic [3:0] OP_MUL = 4'b1011;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// done is high in the last iteration cycle; prod is valid alongside it.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] prod
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] acc_next;

   always_comb begin
      addend   = mplier_q[0] ? mcand_q : '0;
      acc_next = acc_q + addend;
      // Final sum is exposed combinationally so the top can load it on the last edge
      done     = busy_q && (cnt_q == SHW'(WIDTH - 1));
      prod     = acc_next;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         mcand_d  = a;
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         acc_d    = acc_next;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (done) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked registered ALU: op decode, control FSM and output registers.
// Multiply is delegated to alu_mul_seq when MUL_EN is set.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             zero,
   output logic             carry,
   output logic             ovf
);

   localparam int SHW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;

   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   sum_add;
   logic [WIDTH:0]   sum_sub;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic             alu_ill;
   logic             alu_zero;
   logic             is_mul;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_prod;

   assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign out_valid = (state_q == DONE);
   assign res       = res_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;
   assign is_mul    = MUL_EN && (op == OP_MUL);

   always_comb begin
      shamt   = b[SHW-1:0];
      sum_add = {1'b0, a} + {1'b0, b};
      sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_ill = 1'b0;
      unique case (op)
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_NOR: alu_res = ~(a | b);
         OP_ADD: begin
            alu_res = sum_add[WIDTH-1:0];
            alu_c   = sum_add[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                      (sum_add[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sum_sub[WIDTH-1:0];
            alu_c   = sum_sub[WIDTH];
            alu_v   = (a[WIDTH-1] == ~b[WIDTH-1]) &&
                      (sum_sub[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL: alu_res = a << shamt;
         OP_SRL: alu_res = a >> shamt;
         OP_SRA: alu_res = $signed(a) >>> shamt;
         // MUL never reaches this path when enabled; otherwise it is undefined
         default: alu_ill = 1'b1;
      endcase
      alu_zero = !alu_ill && (alu_res == '0);
   end

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      mul_start = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (in_ready) begin
               if (in_valid && is_mul) begin
                  state_d   = MUL;
                  mul_start = 1'b1;
               end else if (in_valid) begin
                  state_d = DONE;
                  res_d   = alu_res;
                  zero_d  = alu_zero;
                  carry_d = alu_c;
                  ovf_d   = alu_v;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         MUL: begin
            if (mul_done) begin
               state_d = DONE;
               res_d   = mul_prod;
               zero_d  = (mul_prod == '0);
               carry_d = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   generate
      if (MUL_EN) begin : g_mul
         alu_mul_seq #(
            .WIDTH(WIDTH)
         ) u_mul (
            .clk  (clk),
            .rst  (rst),
            .start(mul_start),
            .a    (a),
            .b    (b),
            .done (mul_done),
            .prod (mul_prod)
         );
      end else begin : g_no_mul
         assign mul_done = 1'b0;
         assign mul_prod = '0;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table, scoreboard and
// hand-written multiply, back-pressure and reset sequences.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
      logic         c;
      logic         v;
   } exp_t;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      exp_t         e;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   op = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] res;
   logic         zero;
   logic         carry;
   logic         ovf;

   exp_t exp_q[$];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   alu_seq #(
      .WIDTH (W),
      .MUL_EN(1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .op       (op),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .res      (res),
      .zero     (zero),
      .carry    (carry),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic exp_t mk_e(input logic [W-1:0] r, input logic z,
                                 input logic c, input logic v);
      exp_t e;
      e.res = r;
      e.z   = z;
      e.c   = c;
      e.v   = v;
      return e;
   endfunction

   function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W-1:0] r,
                               input logic z, input logic c, input logic v);
      vec_t t;
      t.op = o;
      t.a  = x;
      t.b  = y;
      t.e  = mk_e(r, z, c, v);
      return t;
   endfunction

   // Called just after a rising edge; returns 1 ns after the accepting edge.
   task automatic send(input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input exp_t e, input bit push);
      int n = 0;
      op       = o;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      if (push) exp_q.push_back(e);
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("accept", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got res %0h, expected none", res);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", 64'({res, zero, carry, ovf}), 64'(e));
         end
      end
   end

   initial begin
      int n;
      int bad;
      time t0;

      vecs.push_back(mk(OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 1, 0));
      vecs.push_back(mk(OP_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 1, 1));
      vecs.push_back(mk(OP_SLT, 32'hFFFFFFFF, 32'h0, 32'h1, 0, 0, 0));
      vecs.push_back(mk(OP_SLT, 32'h1, 32'hFFFFFFFF, 32'h0, 1, 0, 0));
      vecs.push_back(mk(OP_SRA, 32'h80000000, 32'h24, 32'hF8000000, 0, 0, 0));
      vecs.push_back(mk(OP_SLL, 32'h00000003, 32'd31, 32'h80000000, 0, 0, 0));
      vecs.push_back(mk(OP_SRL, 32'h80000000, 32'h3F, 32'h1, 0, 0, 0));
      vecs.push_back(mk(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0));
      vecs.push_back(mk(OP_OR,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 0, 0, 0));
      vecs.push_back(mk(OP_NOR, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 0));
      vecs.push_back(mk(OP_NOR, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 0, 0));
      vecs.push_back(mk(OP_SUB, 32'h5, 32'h7, 32'hFFFFFFFE, 0, 0, 0));
      vecs.push_back(mk(OP_SUB, 32'h7, 32'h7, 32'h0, 1, 1, 0));
      vecs.push_back(mk(OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1));
      vecs.push_back(mk(4'b0011, 32'h12345678, 32'h9, 32'h0, 0, 0, 0));
      vecs.push_back(mk(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 0, 0));

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_outputs", 64'({res, zero, carry, ovf}), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Table, back-to-back with latency-1 check on each op
      foreach (vecs[i]) begin
         send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
         chk("latency1", 64'(out_valid), 64'd1);
      end
      drain();

      // Multiply latency and in_ready low throughout
      send(OP_MUL, 32'd12345, 32'd6789, mk_e(32'd83810205, 0, 0, 0), 1'b1);
      n   = 0;
      bad = 0;
      while (!out_valid && n < 100) begin
         if (in_ready) bad++;
         @(posedge clk);
         #1 n++;
      end
      chk("mul_latency", 64'(n), 64'd32);
      chk("mul_in_ready_low", 64'(bad), 64'd0);
      send(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, mk_e(32'h1, 0, 0, 0), 1'b1);
      send(OP_MUL, 32'h00010000, 32'h00010000, mk_e(32'h0, 1, 0, 0), 1'b1);
      drain();

      // Back-pressure hold, then back-to-back throughput
      out_ready = 1'b0;
      send(OP_ADD, 32'd5, 32'd7, mk_e(32'd12, 0, 0, 0), 1'b1);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (!out_valid || in_ready || res !== 32'd12 ||
             {zero, carry, ovf} !== 3'b000) bad++;
      end
      chk("backpressure_hold", 64'(bad), 64'd0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      t0 = $time;
      send(OP_ADD, 32'd1, 32'd2, mk_e(32'd3, 0, 0, 0), 1'b1);
      send(OP_SUB, 32'd10, 32'd3, mk_e(32'd7, 0, 1, 0), 1'b1);
      send(OP_OR, 32'hA0, 32'h0B, mk_e(32'hAB, 0, 0, 0), 1'b1);
      send(OP_SLL, 32'h1, 32'd4, mk_e(32'h10, 0, 0, 0), 1'b1);
      chk("throughput", 64'(($time - t0) / 10), 64'd4);
      drain();

      // Reset during multiply iteration 10
      send(OP_MUL, 32'd3, 32'd5, mk_e(32'd0, 0, 0, 0), 1'b0);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midmul_rst_outputs", 64'({out_valid, res, zero, carry, ovf}), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midmul_in_ready", 64'(in_ready), 64'd1);
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) bad++;
      end
      chk("midmul_no_valid", 64'(bad), 64'd0);
      chk("midmul_queue", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
